// File: rtl/comparador_pkg.sv
// Shared types and constants for the bit-serial comparator.
package comparador_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Decision code (x,y). 2'b11 is never produced.
   localparam logic [1:0] EQ_SO_FAR = 2'b00;
   localparam logic [1:0] A_MAYOR   = 2'b10;
   localparam logic [1:0] A_MENOR   = 2'b01;

endpackage

// File: rtl/comparador_secuencial_if.sv
// Operand/result bundle between a requester and the comparator.
interface comparador_secuencial_if #(
   parameter int WIDTH = 8
);
   import comparador_pkg::*;

   // Handshake: start is sampled on a rising edge only while the comparator is
   // idle (busy=0 and done=0); a and b must be valid in that same cycle. While
   // busy or done is high, start and the operands are ignored. done pulses for
   // exactly one cycle, and gt/eq/lt stay valid from then until the next
   // accepted start.
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;
   state_t           dbg_state;

   modport master (output start, a, b,
                   input  busy, done, gt, eq, lt, dbg_state);
   modport slave  (input  start, a, b,
                   output busy, done, gt, eq, lt, dbg_state);

endinterface

// File: rtl/comparador_secuencial_celda_tipica.sv
// One step of the MSB-first comparison: folds one bit pair into the
// decision code. A decided code (x or y set) is passed through unchanged.
module celda_tipica (
   input  logic A,
   input  logic B,
   input  logic x,
   input  logic y,
   output logic f_mid,
   output logic g_mid
);

   assign f_mid = x | (~y & A & ~B);
   assign g_mid = y | (~x & ~A & B);

endmodule

// File: rtl/comparador_secuencial.sv
// Bit-serial magnitude comparator: shifts both operands out MSB first and
// stops on the last bit, or on the first differing bit when EARLY_EXIT=1.
module comparador_secuencial #(
   parameter int WIDTH       = 8,
   parameter int SIGNED_MODE = 0,
   parameter int EARLY_EXIT  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   comparador_secuencial_if.slave bus
);
   import comparador_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_xy;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic             w_first;
   logic             w_cell_a;
   logic             w_cell_b;
   logic [1:0]       w_xy_next;

   // The counter still holds WIDTH only while the sign bit is being examined.
   assign w_first = (r_cnt == CW'(WIDTH));

   // In signed mode the sign bit ranks the opposite way, so swap the operands
   // fed to the cell for that one bit.
   always_comb begin
      w_cell_a = r_a[WIDTH-1];
      w_cell_b = r_b[WIDTH-1];
      if ((SIGNED_MODE != 0) && w_first) begin
         w_cell_a = r_b[WIDTH-1];
         w_cell_b = r_a[WIDTH-1];
      end
   end

   celda_tipica u_celda (
      .A     (w_cell_a),
      .B     (w_cell_b),
      .x     (r_xy[1]),
      .y     (r_xy[0]),
      .f_mid (w_xy_next[1]),
      .g_mid (w_xy_next[0])
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next state: finish on the last bit, or as soon as the code is decided.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_next = COMPARE;
         COMPARE: if ((r_cnt == CW'(1)) ||
                      ((EARLY_EXIT != 0) && (w_xy_next != EQ_SO_FAR)))
                     w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: capture on accept, shift/count while comparing, latch result on exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_xy  <= EQ_SO_FAR;
         r_gt  <= 1'b0;
         r_eq  <= 1'b0;
         r_lt  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a   <= bus.a;
                  r_b   <= bus.b;
                  r_cnt <= CW'(WIDTH);
                  r_xy  <= EQ_SO_FAR;
                  r_gt  <= 1'b0;
                  r_eq  <= 1'b0;
                  r_lt  <= 1'b0;
               end
            end
            COMPARE: begin
               r_a  <= r_a << 1;
               r_b  <= r_b << 1;
               r_xy <= w_xy_next;
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
               if (w_state_next == DONE) begin
                  r_gt <= (w_xy_next == A_MAYOR);
                  r_lt <= (w_xy_next == A_MENOR);
                  r_eq <= (w_xy_next == EQ_SO_FAR);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (r_state == COMPARE);
   assign bus.done      = (r_state == DONE);
   assign bus.gt        = r_gt;
   assign bus.eq        = r_eq;
   assign bus.lt        = r_lt;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_comparador_secuencial.sv
// Bench for comparador_secuencial across five parameter sets, with a
// plain-arithmetic reference for the result and the completion latency.
module tb_comparador_secuencial;

   logic        clk;
   logic        reset;
   logic        start_v [5];
   logic [31:0] a_v     [5];
   logic [31:0] b_v     [5];
   logic        busy_v  [5];
   logic        done_v  [5];
   logic [2:0]  res_v   [5];   // {gt, eq, lt}
   logic [1:0]  st_v    [5];

   int total = 0;
   int bad   = 0;

   // Configurations: 0 W8 unsigned early, 1 W8 signed early, 2 W8 unsigned full,
   // 3 W1 unsigned early, 4 W5 signed full.
   function automatic int cfg_w(input int i);
      case (i)
         3:       return 1;
         4:       return 5;
         default: return 8;
      endcase
   endfunction

   function automatic bit cfg_s(input int i);
      return (i == 1) || (i == 4);
   endfunction

   function automatic bit cfg_e(input int i);
      return (i == 0) || (i == 1) || (i == 3);
   endfunction

   comparador_secuencial_if #(.WIDTH(8)) if0 ();
   comparador_secuencial_if #(.WIDTH(8)) if1 ();
   comparador_secuencial_if #(.WIDTH(8)) if2 ();
   comparador_secuencial_if #(.WIDTH(1)) if3 ();
   comparador_secuencial_if #(.WIDTH(5)) if4 ();

   comparador_secuencial #(.WIDTH(8), .SIGNED_MODE(0), .EARLY_EXIT(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
   comparador_secuencial #(.WIDTH(8), .SIGNED_MODE(1), .EARLY_EXIT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
   comparador_secuencial #(.WIDTH(8), .SIGNED_MODE(0), .EARLY_EXIT(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
   comparador_secuencial #(.WIDTH(1), .SIGNED_MODE(0), .EARLY_EXIT(1)) u3 (.clk(clk), .reset(reset), .bus(if3));
   comparador_secuencial #(.WIDTH(5), .SIGNED_MODE(1), .EARLY_EXIT(0)) u4 (.clk(clk), .reset(reset), .bus(if4));

   assign if0.start = start_v[0];  assign if0.a = a_v[0][7:0];  assign if0.b = b_v[0][7:0];
   assign if1.start = start_v[1];  assign if1.a = a_v[1][7:0];  assign if1.b = b_v[1][7:0];
   assign if2.start = start_v[2];  assign if2.a = a_v[2][7:0];  assign if2.b = b_v[2][7:0];
   assign if3.start = start_v[3];  assign if3.a = a_v[3][0:0];  assign if3.b = b_v[3][0:0];
   assign if4.start = start_v[4];  assign if4.a = a_v[4][4:0];  assign if4.b = b_v[4][4:0];

   assign busy_v[0] = if0.busy;  assign done_v[0] = if0.done;  assign res_v[0] = {if0.gt, if0.eq, if0.lt};  assign st_v[0] = if0.dbg_state;
   assign busy_v[1] = if1.busy;  assign done_v[1] = if1.done;  assign res_v[1] = {if1.gt, if1.eq, if1.lt};  assign st_v[1] = if1.dbg_state;
   assign busy_v[2] = if2.busy;  assign done_v[2] = if2.done;  assign res_v[2] = {if2.gt, if2.eq, if2.lt};  assign st_v[2] = if2.dbg_state;
   assign busy_v[3] = if3.busy;  assign done_v[3] = if3.done;  assign res_v[3] = {if3.gt, if3.eq, if3.lt};  assign st_v[3] = if3.dbg_state;
   assign busy_v[4] = if4.busy;  assign done_v[4] = if4.done;  assign res_v[4] = {if4.gt, if4.eq, if4.lt};  assign st_v[4] = if4.dbg_state;

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: numeric compare of the operands as integers, latency from the
   // position of the most significant differing bit.
   function automatic void ref_model(input int i, input logic [31:0] a, input logic [31:0] b,
                                     output int k, output logic [2:0] res);
      int          w;
      logic [31:0] mask, av, bv, diff;
      longint      sa, sb;
      w    = cfg_w(i);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      av   = a & mask;
      bv   = b & mask;
      sa   = longint'(av);
      sb   = longint'(bv);
      if (cfg_s(i) && av[w-1]) sa = sa - (longint'(1) << w);
      if (cfg_s(i) && bv[w-1]) sb = sb - (longint'(1) << w);
      res  = {sa > sb, sa == sb, sa < sb};
      diff = av ^ bv;
      k    = w;
      if (cfg_e(i) && (diff != 32'h0)) begin
         for (int p = 0; p < w; p++)
            if (diff[p]) k = w - p;
      end
   endfunction

   // One transaction on DUT i; optionally raise a second start while comparing.
   task automatic run(input int i, input logic [31:0] a, input logic [31:0] b, input bit intrude);
      int         k, lat;
      logic [2:0] exp;
      bit         busy_ok;
      string      tg;
      ref_model(i, a, b, k, exp);
      tg = $sformatf("dut%0d a=%0h b=%0h", i, a, b);
      @(negedge clk);
      a_v[i] = a; b_v[i] = b; start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      chk({tg, " busy_after_accept"}, 32'(busy_v[i]), 32'd1);
      chk({tg, " res_cleared"}, 32'(res_v[i]), 32'd0);
      if (intrude) begin
         a_v[i] = 32'hFF; b_v[i] = 32'h00; start_v[i] = 1'b1;
      end
      lat = 0;
      busy_ok = 1'b1;
      for (int n = 1; (n <= cfg_w(i) + 4) && (lat == 0); n++) begin
         @(negedge clk);
         start_v[i] = 1'b0;
         if (done_v[i]) lat = n;
         else if (!busy_v[i]) busy_ok = 1'b0;
      end
      chk({tg, " latency"}, 32'(lat), 32'(k));
      chk({tg, " busy_while_comparing"}, 32'(busy_ok), 32'd1);
      if (lat != 0) begin
         chk({tg, " busy_at_done"}, 32'(busy_v[i]), 32'd0);
         chk({tg, " result"}, 32'(res_v[i]), 32'(exp));
         @(negedge clk);
         chk({tg, " done_one_cycle"}, 32'(done_v[i]), 32'd0);
         chk({tg, " result_held"}, 32'(res_v[i]), 32'(exp));
      end
      if (intrude) begin
         for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk({tg, " no_second_op"}, 32'({busy_v[i], done_v[i]}), 32'd0);
         end
      end
   endtask

   task automatic chk_reset_outputs(input int i, input string tag);
      chk($sformatf("%s dut%0d busy", tag, i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("%s dut%0d done", tag, i), 32'(done_v[i]), 32'd0);
      chk($sformatf("%s dut%0d res", tag, i), 32'(res_v[i]), 32'd0);
      chk($sformatf("%s dut%0d state", tag, i), 32'(st_v[i]), 32'd0);
   endtask

   initial begin
      bit          saw_done;
      logic [31:0] ra, rb;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
      end
      #1 reset = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) chk_reset_outputs(i, "reset_state");
      @(posedge clk); @(negedge clk);
      reset = 1'b0;

      // Directed cases.
      run(0, 32'hA5, 32'hA5, 1'b0);   // equal, full 8 cycles
      run(0, 32'h80, 32'h7F, 1'b0);   // unsigned: decided on MSB, gt
      run(1, 32'h80, 32'h7F, 1'b0);   // signed: decided on MSB, lt
      run(2, 32'h03, 32'h05, 1'b0);   // no early exit: 8 cycles, lt
      run(0, 32'h10, 32'h20, 1'b1);   // second start during compare ignored
      run(3, 32'h1,  32'h0,  1'b0);   // single-bit operand
      run(4, 32'h10, 32'h0F, 1'b0);   // signed 5-bit: -16 < 15

      // Reset while idle clears the held result.
      run(0, 32'hF0, 32'h0F, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs(0, "reset_idle");
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a comparison aborts it without a done pulse.
      @(negedge clk);
      a_v[2] = 32'h03; b_v[2] = 32'h05; start_v[2] = 1'b1;
      @(negedge clk);
      start_v[2] = 1'b0;
      @(negedge clk); @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs(2, "reset_mid");
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (done_v[2] || busy_v[2]) saw_done = 1'b1;
      end
      chk("reset_mid no_activity", 32'(saw_done), 32'd0);
      run(2, 32'h03, 32'h05, 1'b0);
      run(2, 32'h9C, 32'h9B, 1'b0);

      // Randomized operands, biased towards equal and single-bit-different pairs.
      for (int i = 0; i < 5; i++) begin
         for (int r = 0; r < 12; r++) begin
            ra = $urandom;
            rb = $urandom;
            if (r % 4 == 0) rb = ra;
            if (r % 4 == 1) rb = ra ^ (32'h1 << $urandom_range(cfg_w(i) - 1, 0));
            run(i, ra, rb, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/comparador_secuencial.md
COMPARADOR_SECUENCIAL -- requirements
Module: comparador_secuencial

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 Parameter SIGNED_MODE, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 Parameter EARLY_EXIT, default 1; 1 = finish as soon as the result is decided, 0 = always process all WIDTH bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to capture operands and begin a comparison.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 busy  output  1  high while bits are being compared.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 gt / eq / lt  output  1 each  registered result: A>B, A==B, A<B; one-hot when valid.

Function
REQ-012 The FSM shall have three states: IDLE, COMPARE, DONE.
REQ-013 In IDLE, start=1 at a rising edge shall capture a and b into left-shift registers, load the bit counter with WIDTH, clear the decision code (x,y)=00, clear gt/eq/lt to 0, and enter COMPARE.
REQ-014 Decision code: 00 = equal so far, 10 = A greater, 01 = A smaller; 11 is unreachable and shall never be produced.
REQ-015 Each COMPARE edge shall evaluate the MSBs of both shift registers (left-to-right, MSB first), update (x,y), shift both registers left by one, and decrement the counter.
REQ-016 Once (x,y) is non-zero, later bits shall not change it.
REQ-017 With SIGNED_MODE=1, the sign bit (first bit evaluated) shall decide with inverted polarity: A=1 and B=0 gives 01; A=0 and B=1 gives 10.
REQ-018 COMPARE shall go to DONE on the edge that processes the last bit (counter 1 to 0).
REQ-019 If EARLY_EXIT=1, COMPARE shall also go to DONE on the edge where the updated (x,y) becomes non-zero.
REQ-020 Entering DONE shall register gt=x, lt=y, eq=~x&~y.
REQ-021 done shall be 1 exactly for the one cycle spent in DONE; DONE shall always return to IDLE on the next edge.
REQ-022 busy shall be 1 in COMPARE only.
REQ-023 gt/eq/lt shall hold their value after done until the next start is accepted.
REQ-024 start shall be ignored in COMPARE and DONE, and the captured operands shall not change.
REQ-025 Latency from the accepting edge t: done is high between edges t+k and t+k+1, where k = WIDTH (no early exit) or k = index of the first differing bit counted from the MSB, starting at 1.
REQ-026 WIDTH=1 shall complete in one COMPARE cycle.
REQ-027 The counter width shall be $clog2(WIDTH+1) bits, with no wrap-around beyond 0.

Reset
REQ-028 reset=1 shall immediately, independent of clk, force IDLE, busy=0, done=0, gt=eq=lt=0, counter=0, (x,y)=00, and shift registers=0.
REQ-029 Reset during COMPARE or DONE shall abort the operation with no done pulse; the first start after reset deasserts shall be accepted normally.

Structure
REQ-030 Package comparador_pkg shall hold the state encoding (IDLE, COMPARE, DONE) and the decision-code constants (EQ_SO_FAR, A_MAYOR, A_MENOR).
REQ-031 The per-bit update shall be the combinational sub-module celda_tipica (inputs A, B, x, y; outputs f_mid, g_mid = next x, next y) implementing REQ-014/016 encoding.
REQ-032 Sign-bit inversion shall be done by swapping the A and B inputs to celda_tipica on the first bit.

Verification
REQ-033 WIDTH=8, a=8'hA5, b=8'hA5, start at edge t -> busy edges t..t+8, done high t+8..t+9, eq=1.
REQ-034 a=8'h80, b=8'h7F, EARLY_EXIT=1: unsigned -> done high t+1..t+2, gt=1; SIGNED_MODE=1 -> same timing, lt=1.
REQ-035 a=8'h03, b=8'h05, EARLY_EXIT=0 -> done at t+8, lt=1, gt=eq=0.
REQ-036 Start with a=8'h10, b=8'h20, then start with a=8'hFF, b=8'h00 during COMPARE -> second start ignored, lt=1, single done pulse.
REQ-037 Reset pulse mid-COMPARE -> all outputs 0 asynchronously, no done; a new start afterwards gives the correct result with REQ-025 timing.
REQ-038 WIDTH=1, a=1, b=0 -> done at t+1, gt=1.
